program_sequencer: RTL and testbench
====================================

# program_sequencer

Run controller for the single-cycle processor core. It accepts a four-phase `req`/`done` handshake from the host or testbench and holds the core in reset for a fixed number of cycles. It then releases the core, counts executed cycles, and detects the core's halt. An optional watchdog aborts runaway programs. It sits between the host and `top_level`: it drives the core's `reset` and its run enable, and observes the core's `done` as `core_halt`.

## Interface
Parameters:
- `CW`, 16: cycle-counter width.
- `RST_CYCLES`, 2: number of cycles `core_reset` is held after a start (≥1).
- `TIMEOUT`, 4000: watchdog limit in RUN cycles (1 ≤ TIMEOUT ≤ 2^CW−1). Used only when the watchdog is compiled in.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: host start request, four-phase.
- `done` output 1: run finished (registered).
- `core_halt` input 1: core's `done` output.
- `core_reset` output 1: drives the core's `reset`.
- `run_en` output 1: core clock enable / PC advance enable.
- `cycle_count` output CW: RUN cycles counted in the current or last run.
- `timeout` output 1: last run ended by the watchdog.

## Operation
- States: IDLE, CORE_RST, RUN, FINISH. State is held in a 2-bit register.
- Reset (`reset`=1): state goes to IDLE. Outputs: `core_reset`=1, `run_en`=0, `done`=0, `cycle_count`=0, `timeout`=0.
- IDLE:
  - `core_reset`=1, `run_en`=0, `done`=0.
  - `req`=1 → CORE_RST. On that transition `cycle_count`=0, `timeout`=0, and the reset counter loads `RST_CYCLES`−1.
- CORE_RST:
  - `core_reset`=1, `run_en`=0.
  - The reset counter decrements each cycle. At 0 the state goes to RUN.
- RUN: `core_reset`=0, `run_en`=1. Each cycle, in priority order:
  - `core_halt`=1 → FINISH. No increment.
  - Else, if the watchdog is enabled and `cycle_count`==`TIMEOUT`−1 → increment, go to FINISH, set `timeout`=1.
  - Else, increment `cycle_count`, saturating at 2^CW−1 (no wrap).
- FINISH:
  - `done`=1, `run_en`=0, `core_reset`=0. Core state is frozen so the host can read data memory.
  - Stay while `req`=1. `req`=0 → IDLE, `done`=0.
- `req` falling during CORE_RST or RUN is ignored; the run completes.
- `req` held high through FINISH never restarts a run. A new run requires `req` low then high.
- `core_halt` is ignored outside RUN.
- `reset` overrides every state, including mid-run.

## Timing
- `req` sampled high in cycle t: CORE_RST spans t+1 … t+`RST_CYCLES`, and RUN starts at t+`RST_CYCLES`+1.
- `core_halt` sampled high in cycle h: `done`=1 and `run_en`=0 from h+1.
- `req` sampled low in FINISH at cycle f: `done`=0 and `core_reset`=1 from f+1.
- Every output is registered or decoded from registered state. There is no combinational path from `req` or `core_halt` to any output.
- Watchdog latency: FINISH is entered exactly `TIMEOUT` RUN cycles after RUN entry, with `cycle_count`=`TIMEOUT`.

## Configuration
- Macro: `PROGRAM_SEQUENCER_WATCHDOG_EN`.
- Defined: watchdog comparison active; `timeout` behaves as in Operation.
- Undefined: no comparator; `timeout` is tied to 0; `TIMEOUT` is unused. RUN exits only on `core_halt` or `reset`. `cycle_count` still saturates.

## Structure
- Package `program_sequencer_pkg`:
  - typedef enum `seq_state_t` {IDLE, CORE_RST, RUN, FINISH}.
  - Default constants `SEQ_CW`, `SEQ_RST_CYCLES`, `SEQ_TIMEOUT`.
- Sub-module `sat_counter` (parameter W; inputs `clr`, `inc`; output `q`): saturating up-counter used for `cycle_count`.
- The FSM and the reset down-counter stay in the top module.

## Test plan
All scenarios use CW=8, RST_CYCLES=2, TIMEOUT=20, watchdog enabled unless noted.
- Reset held 3 cycles → `core_reset`=1, `run_en`=0, `done`=0, `cycle_count`=0, `timeout`=0 throughout.
- `req`=1 at t=0, `core_halt`=1 at t=8 → `core_reset` high through t=2, `run_en` high t=3..8, `done`=1 at t=9, `cycle_count`=5, `timeout`=0.
- `core_halt` never rises → `done`=1 at t=23, `cycle_count`=20, `timeout`=1.
- `core_halt` rises exactly when `cycle_count`=19 → FINISH with `cycle_count`=19, `timeout`=0 (halt wins).
- `reset` pulsed at t=5 mid-RUN → t=6 IDLE, `core_reset`=1, `cycle_count`=0.
- Handshake: `req` kept high 4 cycles after `done` → `done` stays 1 and no restart. `req` low, then high again → `done` drops the next cycle, and the new run starts with `cycle_count` cleared.
- Watchdog undefined, CW=4, no halt → `cycle_count` sticks at 15, `timeout`=0, and RUN persists.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and default constants for the program run controller.
// Pulled in by program_sequencer and its sub-modules.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        RUN      = 2'd2,
        FINISH   = 2'd3
    } seq_state_t;

    localparam int SEQ_CW         = 16;
    localparam int SEQ_RST_CYCLES = 2;
    localparam int SEQ_TIMEOUT    = 4000;

    // Width of the core-reset down-counter; it never needs to hold more than cycles-1.
    function automatic int rst_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/program_sequencer_sat_counter.sv
// Saturating up-counter: clears on clr, counts on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != MAX_VAL)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Run controller for the single-cycle core: req/done handshake, core reset hold, cycle count.
// Optional watchdog compiled in with `define PROGRAM_SEQUENCER_WATCHDOG_EN.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int CW         = SEQ_CW,
    parameter int RST_CYCLES = SEQ_RST_CYCLES,
    parameter int TIMEOUT    = SEQ_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    input  logic          core_halt,
    output logic          core_reset,
    output logic          run_en,
    output logic [CW-1:0] cycle_count,
    output logic          timeout
);

    localparam int              RW       = rst_cnt_width(RST_CYCLES);
    localparam logic [RW-1:0]   RST_LOAD = RW'(RST_CYCLES - 1);

    seq_state_t     state;
    logic [RW-1:0]  rst_cnt;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           wd_hit;

    assign cnt_clr = (state == IDLE) && req;
    assign cnt_inc = (state == RUN) && !core_halt;

`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    assign wd_hit = (cycle_count == WD_LAST);
`else
    // TIMEOUT has no effect in this build; the run only ends on core_halt or reset.
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign wd_hit         = 1'b0;
`endif

    sat_counter #(
        .W (CW)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .q     (cycle_count)
    );

    // Outputs are updated together with the state so each one always matches the state it decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b1;
            run_en     <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_reset <= 1'b1;
                    run_en     <= 1'b0;
                    done       <= 1'b0;
                    if (req) begin
                        state   <= CORE_RST;
                        rst_cnt <= RST_LOAD;
                        timeout <= 1'b0;
                    end
                end
                CORE_RST: begin
                    if (rst_cnt == '0) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        run_en     <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
                RUN: begin
                    // A halt in the same cycle as the watchdog limit wins, so timeout stays clear.
                    if (core_halt) begin
                        state  <= FINISH;
                        run_en <= 1'b0;
                        done   <= 1'b1;
                    end else if (wd_hit) begin
                        state   <= FINISH;
                        run_en  <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                FINISH: begin
                    if (!req) begin
                        state      <= IDLE;
                        done       <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    core_reset <= 1'b1;
                    run_en     <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer; follows the watchdog setting of the RTL build.
module tb_program_sequencer;

    localparam int CW  = 8;
    localparam int RST = 2;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          core_halt;
    logic          done;
    logic          core_reset;
    logic          run_en;
    logic [CW-1:0] cycle_count;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int count;
        int tmo;
        int run_start;
        int done_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    program_sequencer #(
        .CW         (CW),
        .RST_CYCLES (RST),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .core_halt   (core_halt),
        .core_reset  (core_reset),
        .run_en      (run_en),
        .cycle_count (cycle_count),
        .timeout     (timeout)
    );

`ifndef PROGRAM_SEQUENCER_WATCHDOG_EN
    logic       req4 = 1'b0;
    logic       halt4 = 1'b0;
    logic       done4;
    logic       core_reset4;
    logic       run_en4;
    logic [3:0] cycle_count4;
    logic       timeout4;

    program_sequencer #(
        .CW         (4),
        .RST_CYCLES (RST),
        .TIMEOUT    (TO)
    ) dut4 (
        .clk         (clk),
        .reset       (reset),
        .req         (req4),
        .done        (done4),
        .core_halt   (halt4),
        .core_reset  (core_reset4),
        .run_en      (run_en4),
        .cycle_count (cycle_count4),
        .timeout     (timeout4)
    );
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle in which req is first driven high.
    function automatic exp_t predict(input int halt_after);
        exp_t e;
        e.run_start = RST + 1;
        e.count     = halt_after;
        e.tmo       = 0;
        e.done_cyc  = RST + 2 + halt_after;
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
        if (halt_after < 0 || halt_after >= TO) begin
            e.count    = TO;
            e.tmo      = 1;
            e.done_cyc = RST + 1 + TO;
        end
`endif
        return e;
    endfunction

    task automatic applyStimulus(input int halt_after, input int hold);
        exp_t e;
        int   cyc;
        int   first_run;
        int   run_cycles;
        sb.push_back(predict(halt_after));
        req        = 1'b1;
        first_run  = -1;
        run_cycles = 0;
        step();
        cyc = 1;
        checkOutput("start_count_clr", cycle_count, 0);
        checkOutput("start_timeout_clr", timeout, 0);
        checkOutput("start_core_reset", core_reset, 1);
        while (!done && cyc < 400) begin
            if (run_en) begin
                if (first_run < 0) first_run = cyc;
                if (run_cycles == halt_after) core_halt = 1'b1;
                run_cycles++;
            end
            step();
            cyc++;
        end
        core_halt = 1'b0;
        e = sb.pop_front();
        checkOutput("done_seen", done, 1);
        checkOutput("run_start", first_run, e.run_start);
        checkOutput("done_cycle", cyc, e.done_cyc);
        checkOutput("final_count", cycle_count, e.count);
        checkOutput("final_timeout", timeout, e.tmo);
        checkOutput("finish_run_en", run_en, 0);
        checkOutput("finish_core_reset", core_reset, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput("hold_done", done, 1);
            checkOutput("hold_no_restart", core_reset, 0);
            checkOutput("hold_count", cycle_count, e.count);
        end
        req = 1'b0;
        step();
        checkOutput("release_done", done, 0);
        checkOutput("release_core_reset", core_reset, 1);
        checkOutput("release_run_en", run_en, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        core_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_core_reset", core_reset, 1);
            checkOutput("rst_run_en", run_en, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_count", cycle_count, 0);
            checkOutput("rst_timeout", timeout, 0);
        end
        reset = 1'b0;
        step();

        applyStimulus(5, 0);
        applyStimulus(19, 0);
        applyStimulus(0, 0);
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
        applyStimulus(-1, 0);
        applyStimulus(7, 0);
`endif
        applyStimulus(3, 4);
        applyStimulus(2, 0);

        req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checkOutput("midrun_run_en", run_en, 1);
        checkOutput("midrun_count", cycle_count, 2);
        reset = 1'b1;
        step();
        checkOutput("midrun_rst_core_reset", core_reset, 1);
        checkOutput("midrun_rst_run_en", run_en, 0);
        checkOutput("midrun_rst_count", cycle_count, 0);
        checkOutput("midrun_rst_done", done, 0);
        reset = 1'b0;
        req   = 1'b0;
        step();
        checkOutput("post_rst_idle", core_reset, 1);

`ifndef PROGRAM_SEQUENCER_WATCHDOG_EN
        req4 = 1'b1;
        for (int i = 0; i < 40; i++) step();
        checkOutput("sat_count", cycle_count4, 15);
        checkOutput("sat_timeout", timeout4, 0);
        checkOutput("sat_run_en", run_en4, 1);
        checkOutput("sat_done", done4, 0);
        req4 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checkOutput("sat_still_run", run_en4, 1);
        checkOutput("sat_still_count", cycle_count4, 15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
